// File: rtl/hilo_div_unit.sv
// Multi-cycle restoring divider writing LO=quotient, HI=remainder; start-to-done WIDTH+1 cycles (1 for divide-by-zero).
// Stalls IF/ID/EX while running or while a new request waits in DONE; optional signed mode under SIGNED_DIV_EN.
module hilo_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             in_neg_q;
  logic             in_neg_r;

  logic             div_zero_in;
  logic             last_step;
  logic             rem_msb;
  logic [WIDTH-1:0] rem_low;
  logic [WIDTH:0]   diff;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

`ifdef SIGNED_DIV_EN
  logic sgn_a;
  logic sgn_b;

  assign sgn_a    = div_signed & dividend[WIDTH-1];
  assign sgn_b    = div_signed & divisor[WIDTH-1];
  assign mag_a    = sgn_a ? -dividend : dividend;
  assign mag_b    = sgn_b ? -divisor : divisor;
  assign in_neg_q = sgn_a ^ sgn_b;
  assign in_neg_r = sgn_a;
`else
  logic unused_div_signed;

  assign unused_div_signed = div_signed;
  assign mag_a    = dividend;
  assign mag_b    = divisor;
  assign in_neg_q = 1'b0;
  assign in_neg_r = 1'b0;
`endif

  assign div_zero_in = (divisor == '0);
  assign last_step   = (count == CNT_W'(WIDTH - 1));

  // Shifted partial remainder is WIDTH+1 bits; when its MSB is set it always
  // exceeds the divisor, and the low WIDTH bits of the difference are exact.
  assign rem_msb  = rem_acc[WIDTH-1];
  assign rem_low  = {rem_acc[WIDTH-2:0], quo[WIDTH-1]};
  assign diff     = {1'b0, rem_low} - {1'b0, dvsr};
  assign trial_ok = rem_msb | ~diff[WIDTH];
  assign rem_step = trial_ok ? diff[WIDTH-1:0] : rem_low;
  assign quo_step = {quo[WIDTH-2:0], trial_ok};

  // Truncation toward zero: quotient sign from operand signs, remainder follows dividend.
  assign q_fin = neg_q ? -quo_step : quo_step;
  assign r_fin = neg_r ? -rem_step : rem_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (div_start) begin
          state_nxt = div_zero_in ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      rem_acc     <= '0;
      quo         <= '0;
      dvsr        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            if (div_zero_in) begin
              lo          <= '1;
              hi          <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              rem_acc <= '0;
              quo     <= mag_a;
              dvsr    <= mag_b;
              neg_q   <= in_neg_q;
              neg_r   <= in_neg_r;
              count   <= '0;
            end
          end
        end
        RUN: begin
          rem_acc <= rem_step;
          quo     <= quo_step;
          count   <= count + CNT_W'(1);
          if (last_step) begin
            lo          <= q_fin;
            hi          <= r_fin;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  // A request seen in DONE is held off one cycle so it is accepted exactly once, from IDLE.
  assign stall = (state == RUN) | ((state == DONE) & div_start) | ((busy & mf_req) & ~(state == DONE));

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Multi-cycle divide unit with HI/LO result registers, serving the EX stage of the pipelined CPU.
- Accepts the "to divd" request from the decoded EX control bundle (E[4]) and computes one quotient bit per cycle.
- Writes LO = quotient and HI = remainder.
- Answers mfhi/mflo reads, and stalls the pipeline while a result is pending.

Parameters:
- WIDTH, 32, operand/result width in bits (even, at least 4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- div_start  in  1  EX-stage divide request (E[4] of the current EX bundle).
- div_signed  in  1  signed-divide select; used only when SIGNED_DIV_EN is defined.
- dividend  in  WIDTH  rs operand.
- divisor  in  WIDTH  rt operand.
- mf_req  in  1  EX stage holds mfhi or mflo (W[3] | W[4]).
- busy  out  1  state != IDLE.
- stall  out  1  freeze IF/ID/EX.
- done  out  1  one-cycle pulse: HI/LO just updated.
- hi  out  WIDTH  HI register (remainder).
- lo  out  WIDTH  LO register (quotient).
- div_by_zero  out  1  sticky flag: last divide had divisor 0.

Behaviour:
- Reset (rst=0, any time, including mid-divide): state=IDLE; counter, working registers, hi, lo = 0; busy=stall=done=div_by_zero=0. An in-flight divide is discarded.
- States: IDLE, RUN, DONE.
- IDLE, div_start=0: hold.
- IDLE, div_start=1, divisor!=0: latch operands, rem_acc=0, quo=dividend, count=0, go to RUN. This is cycle 0.
- IDLE, div_start=1, divisor=0: go to DONE directly (fast path). At the DONE-entry edge: lo = all ones, hi = dividend, div_by_zero=1.
- RUN, each cycle (restoring step):
  - shift {rem_acc,quo} left by 1;
  - trial = rem_acc - divisor (WIDTH+1 bits);
  - if trial is non-negative: rem_acc=trial and quo LSB=1, else quo LSB=0;
  - count+1.
- RUN exit: after WIDTH steps (cycles 1..WIDTH), go to DONE. On the same edge: lo=quo, hi=rem_acc, div_by_zero=0.
- DONE: done=1 for exactly one cycle (cycle WIDTH+1, or cycle 1 on the fast path), then IDLE. hi/lo are valid from the start of DONE.
- Latency: start to done = WIDTH+1 cycles, i.e. 33 for WIDTH=32. Divide by zero: 1 cycle.
- stall = (state==RUN) | (state==DONE & div_start) | (busy & mf_req) & !(state==DONE).
  - mfhi/mflo during RUN stalls until DONE. In DONE the read proceeds and sees the new value.
- div_start while busy is not accepted. The stall keeps EX frozen, so the request stays asserted and is accepted on the first IDLE cycle. No request is ever lost or accepted twice.
- div_start and mf_req together in IDLE: the read returns the old hi/lo, and the divide starts.
- hi/lo change only at the end of a divide or at reset. Outside DONE they never take partial values.
- Operand inputs are ignored except at the accept edge.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined, and div_signed=1 at accept:
  - RUN operates on the magnitudes of dividend and divisor.
  - At the DONE edge, quotient is negated if the operand signs differ, and remainder takes the sign of the dividend (truncation toward zero).
  - Latency is unchanged.
  - Most-negative / -1 gives lo = most-negative, hi = 0 (wrap, no trap).
  - Divide by zero: same fast path, hi = raw dividend.
- Not defined: div_signed is ignored, and all divides are unsigned.

Test Plan:
- Reset, then dividend=100, divisor=7, div_start for one accepted cycle -> done high in cycle 33; lo=14, hi=2, div_by_zero=0; busy high in cycles 1..33.
- dividend=5, divisor=0 -> done in cycle 1; lo=0xFFFFFFFF, hi=5, div_by_zero=1. A following 9/3 divide -> lo=3, hi=0, div_by_zero=0.
- Start 0xFFFFFFFF/0x10, then assert mf_req from cycle 3 -> stall=1 in cycles 3..32, stall=0 in cycle 33; hi=0xF, lo=0x0FFFFFFF.
- div_start held during a RUN (second request 50/5) -> the second divide is accepted only after the first DONE; the second done comes 33 cycles later with lo=10, hi=0; exactly two done pulses.
- rst=0 asynchronously at cycle 10 of a divide -> hi, lo, busy, stall immediately 0; after release, state IDLE and no done pulse.
- With SIGNED_DIV_EN: -7/2, div_signed=1 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Same -7/2 with div_signed=0 -> unsigned result lo=0x7FFFFFFC, hi=1.
